// File: rtl/rx_flow_pkg.sv
// Shared types and constants for the receive flow controller.
package rx_flow_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_SAT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic              parity_err;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  // Saturating increment for the 8-bit event counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Pointer/level FIFO with show-ahead head and simultaneous push/pop support.
module rx_fifo
  import rx_flow_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  rx_entry_t                wr_entry,
  output rx_entry_t                head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  rx_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign push_ok = push & (~full | pop_ok);
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Next fill level; push and pop together cancel out
  always_comb begin
    level_nxt_c = level;
    if (push_ok && !pop_ok) begin
      level_nxt_c = level + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_nxt_c = level - LVL_W'(1);
    end
  end

  // Storage, pointers and level; pointers wrap naturally at DEPTH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level_nxt_c;
    end
  end

endmodule

// File: rtl/rx_flow_ctrl.sv
// Receive flow controller: UART byte capture, FIFO buffering, CTS hysteresis.
// Optional build macro RX_PARITY_DROP_EN: discard bytes flagged with a parity error.
module rx_flow_ctrl
  import rx_flow_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HIGH_WATER = 6,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   uart_new_data,
  input  logic [7:0]             uart_data,
  input  logic                   uart_parity_err,
  output logic                   uart_data_read,
  output logic                   cts,
  output logic [7:0]             nios_data,
  output logic                   nios_parity_err,
  output logic                   nios_valid,
  input  logic                   nios_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             overflow_cnt,
  output logic [7:0]             parity_cnt
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  cap_state_e       state;
  cap_state_e       state_nxt;
  logic             ack_q;
  logic             ack_d;
  logic             pop_c;
  logic             capture_c;
  logic             drop_c;
  logic             push_c;
  logic             ovf_c;
  logic             fifo_empty;
  logic             fifo_full;
  logic [LVL_W-1:0] level_nxt_c;
  rx_entry_t        wr_entry;
  rx_entry_t        head;

`ifdef RX_PARITY_DROP_EN
  assign drop_c          = uart_parity_err;
  assign nios_parity_err = 1'b0;
`else
  assign drop_c          = 1'b0;
  assign nios_parity_err = head.parity_err;
`endif

  assign wr_entry   = '{parity_err: uart_parity_err, data: uart_data};
  assign nios_data  = head.data;
  assign nios_valid = ~fifo_empty;

  // Pop on a rising edge of the registered PIO ack, only when data is present
  assign pop_c = ack_q & ~ack_d & ~fifo_empty;

  // Capture decode; a full FIFO still accepts when a pop frees a slot this cycle
  assign capture_c = (state == ST_IDLE) & uart_new_data;
  assign push_c    = capture_c & ~drop_c & (~fifo_full | pop_c);
  assign ovf_c     = capture_c & ~drop_c & fifo_full & ~pop_c;

  // Capture FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (uart_new_data) state_nxt = ST_ACK;
      ST_ACK:      state_nxt = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!uart_new_data) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State, acknowledge pulse and PIO ack edge-detect registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      uart_data_read <= 1'b0;
      ack_q          <= 1'b0;
      ack_d          <= 1'b0;
    end else begin
      state          <= state_nxt;
      uart_data_read <= (state_nxt == ST_ACK);
      ack_q          <= nios_ack;
      ack_d          <= ack_q;
    end
  end

  // CTS hysteresis on the post-edge fill level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cts <= 1'b1;
    end else if (level_nxt_c >= LVL_W'(HIGH_WATER)) begin
      cts <= 1'b0;
    end else if (level_nxt_c <= LVL_W'(LOW_WATER)) begin
      cts <= 1'b1;
    end
  end

  // Saturating overflow and parity-error counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_cnt <= '0;
      parity_cnt   <= '0;
    end else begin
      if (ovf_c) begin
        overflow_cnt <= sat_inc(overflow_cnt);
      end
      if (capture_c && uart_parity_err) begin
        parity_cnt <= sat_inc(parity_cnt);
      end
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push_c),
    .pop         (pop_c),
    .wr_entry    (wr_entry),
    .head        (head),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .level       (level),
    .level_nxt_c (level_nxt_c)
  );

endmodule

// File: tb/tb_rx_flow_ctrl.sv
// Directed self-checking bench for rx_flow_ctrl (default DEPTH=8, HIGH=6, LOW=2).
module tb_rx_flow_ctrl;

  logic       clock;
  logic       reset;
  logic       uart_new_data;
  logic [7:0] uart_data;
  logic       uart_parity_err;
  logic       uart_data_read;
  logic       cts;
  logic [7:0] nios_data;
  logic       nios_parity_err;
  logic       nios_valid;
  logic       nios_ack;
  logic [3:0] level;
  logic [7:0] overflow_cnt;
  logic [7:0] parity_cnt;

  int tests;
  int fails;
  int read_pulses;

  rx_flow_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .uart_new_data   (uart_new_data),
    .uart_data       (uart_data),
    .uart_parity_err (uart_parity_err),
    .uart_data_read  (uart_data_read),
    .cts             (cts),
    .nios_data       (nios_data),
    .nios_parity_err (nios_parity_err),
    .nios_valid      (nios_valid),
    .nios_ack        (nios_ack),
    .level           (level),
    .overflow_cnt    (overflow_cnt),
    .parity_cnt      (parity_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs are driven and outputs sampled here
  task automatic step();
    @(posedge clock);
    #1;
    if (uart_data_read === 1'b1) read_pulses++;
  endtask

  // Full handshake for one byte: capture edge, ACK edge, WAIT_CLR->IDLE edge
  task automatic push_byte(input logic [7:0] d, input logic p);
    uart_new_data   = 1'b1;
    uart_data       = d;
    uart_parity_err = p;
    step();
    uart_new_data   = 1'b0;
    uart_parity_err = 1'b0;
    step();
    step();
  endtask

  // Rising PIO ack; pop lands on the second edge
  task automatic pop_byte();
    nios_ack = 1'b1;
    step();
    step();
    nios_ack = 1'b0;
    step();
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    read_pulses     = 0;
    reset           = 1'b0;
    uart_new_data   = 1'b0;
    uart_data       = 8'h00;
    uart_parity_err = 1'b0;
    nios_ack        = 1'b0;

    // Reset state
    #12;
    check("rst_level", 32'(level), 0);
    check("rst_cts", 32'(cts), 1);
    check("rst_valid", 32'(nios_valid), 0);
    check("rst_data", 32'(nios_data), 0);
    check("rst_perr", 32'(nios_parity_err), 0);
    check("rst_read", 32'(uart_data_read), 0);
    check("rst_ovf", 32'(overflow_cnt), 0);
    check("rst_par", 32'(parity_cnt), 0);
    reset = 1'b1;
    step();

    // Single byte: push latency and ack pulse width
    read_pulses = 0;
    uart_new_data = 1'b1;
    uart_data     = 8'hA5;
    step();
    check("single_read_hi", 32'(uart_data_read), 1);
    check("single_level", 32'(level), 1);
    check("single_valid", 32'(nios_valid), 1);
    check("single_data", 32'(nios_data), 32'hA5);
    uart_new_data = 1'b0;
    step();
    check("single_read_lo", 32'(uart_data_read), 0);
    step();
    nios_ack = 1'b1;
    step();
    check("pop_not_yet", 32'(level), 1);
    step();
    check("pop_level", 32'(level), 0);
    check("pop_valid", 32'(nios_valid), 0);
    nios_ack = 1'b0;
    step();

    // Held new_data for 10 cycles: one entry, one ack pulse
    read_pulses   = 0;
    uart_new_data = 1'b1;
    uart_data     = 8'h3C;
    for (int i = 0; i < 10; i++) step();
    uart_new_data = 1'b0;
    step();
    step();
    check("held_level", 32'(level), 1);
    check("held_data", 32'(nios_data), 32'h3C);
    check("held_reads", 32'(read_pulses), 1);
    pop_byte();
    check("held_pop", 32'(level), 0);

    // CTS hysteresis
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i), 1'b0);
    check("cts_l5", 32'(cts), 1);
    uart_new_data = 1'b1;
    uart_data     = 8'h15;
    step();
    check("cts_l6_fall", 32'(cts), 0);
    uart_new_data = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) pop_byte();
    check("cts_l3_level", 32'(level), 3);
    check("cts_l3_hold", 32'(cts), 0);
    pop_byte();
    check("cts_l2_level", 32'(level), 2);
    check("cts_l2_rise", 32'(cts), 1);
    pop_byte();
    pop_byte();
    check("cts_empty", 32'(level), 0);

    // Overflow: 10 pushes into 8 slots
    read_pulses = 0;
    for (int i = 0; i < 10; i++) push_byte(8'(8'h20 + i), 1'b0);
    check("ovf_level", 32'(level), 8);
    check("ovf_cnt", 32'(overflow_cnt), 2);
    check("ovf_reads", 32'(read_pulses), 10);
    check("ovf_head", 32'(nios_data), 32'h20);
    check("ovf_cts", 32'(cts), 0);

    // Push and pop on the same edge while full
    nios_ack = 1'b1;
    step();
    uart_new_data = 1'b1;
    uart_data     = 8'hEE;
    step();
    check("simul_level", 32'(level), 8);
    check("simul_ovf", 32'(overflow_cnt), 2);
    check("simul_head", 32'(nios_data), 32'h21);
    uart_new_data = 1'b0;
    nios_ack      = 1'b0;
    step();
    step();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("drain_%0d", i), 32'(nios_data), 32'(8'h21 + 8'(i)));
      pop_byte();
    end
    check("drain_last", 32'(nios_data), 32'hEE);
    pop_byte();
    check("drain_level", 32'(level), 0);
    check("drain_cts", 32'(cts), 1);
    check("drain_ovf", 32'(overflow_cnt), 2);

    // Parity-error byte
    push_byte(8'h81, 1'b1);
    check("par_cnt", 32'(parity_cnt), 1);
`ifdef RX_PARITY_DROP_EN
    check("par_level", 32'(level), 0);
    check("par_perr", 32'(nios_parity_err), 0);
`else
    check("par_level", 32'(level), 1);
    check("par_data", 32'(nios_data), 32'h81);
    check("par_perr", 32'(nios_parity_err), 1);
    pop_byte();
`endif

    // Reset during ACK, byte still pending afterwards is captured as new
    uart_new_data = 1'b1;
    uart_data     = 8'h55;
    step();
    check("mid_pre_level", 32'(level), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_read", 32'(uart_data_read), 0);
    check("mid_rst_par", 32'(parity_cnt), 0);
    check("mid_rst_ovf", 32'(overflow_cnt), 0);
    reset = 1'b1;
    step();
    check("mid_recap_level", 32'(level), 1);
    check("mid_recap_data", 32'(nios_data), 32'h55);
    check("mid_recap_read", 32'(uart_data_read), 1);
    uart_new_data = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
